tx_framer: RTL and testbench
============================

Name: tx_framer

Overview:
- Transmit-side packet framer for the PCIe 8b/10b byte lane.
- Accepts TLP and DLLP byte streams from the link layer.
- Emits a byte stream with D/K flag: STP/SDP start symbols, payload data bytes, and an END or EDB terminator.
- Sits ahead of the 8b/10b encoder. Its output is exactly what the receive-side byte classifier parses back into start/data/end/EDB types.

Parameters:
- DLLP_LEN, 6, fixed DLLP payload length in bytes; the framer ends a DLLP after this count.
- MAX_TLP_LEN, 4096, maximum TLP payload bytes before a forced EDB abort.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tlp_valid  in  1  TLP byte available.
- tlp_data  in  8  TLP byte.
- tlp_last  in  1  marks final TLP byte.
- tlp_nullify  in  1  qualifies tlp_last; terminate with EDB instead of END.
- tlp_ready  out  1  framer consumes the TLP byte this cycle.
- dllp_valid  in  1  DLLP byte available.
- dllp_data  in  8  DLLP byte.
- dllp_ready  out  1  framer consumes the DLLP byte this cycle.
- data_out  out  8  framed byte.
- dk_out  out  1  1 = K (control) symbol, 0 = D symbol.
- valid_out  out  1  data_out/dk_out meaningful.
- tlp_or_dllp  out  2  01 = TLP in flight, 10 = DLLP in flight, 00 = none.
- underrun_err  out  1  one-cycle pulse on payload underrun.
- oversize_err  out  1  one-cycle pulse on MAX_TLP_LEN overflow.

Behaviour:
- Symbol constants:
  - STP = 0xFB (K).
  - SDP = 0x5C (K).
  - END = 0xFD (K).
  - EDB = 0xFE (K).
  - PAD = 0xF7 (K), reserved/unused here.
- All outputs are registered; one cycle from the accepting edge to data_out.
- Reset (async, rst_n=0) values:
  - State = IDLE.
  - data_out = 0x00, dk_out = 0, valid_out = 0.
  - tlp_or_dllp = 00.
  - Error pulses = 0; counters = 0; nullify latch cleared.
- FSM states: IDLE, TLP_PAY, DLLP_PAY, TERM.
- IDLE:
  - ready outputs = 0.
  - If dllp_valid: emit SDP (dk=1, valid=1), tlp_or_dllp = 10, go to DLLP_PAY. DLLP has priority on a simultaneous request.
  - Else if tlp_valid: emit STP, tlp_or_dllp = 01, go to TLP_PAY.
  - Else: valid_out = 0, data_out = 0x00, dk_out = 0.
- TLP_PAY:
  - tlp_ready = 1 (combinational on state).
  - On tlp_valid: emit tlp_data (dk=0) and increment byte count.
  - If tlp_last: latch tlp_nullify and go to TERM.
  - If count reaches MAX_TLP_LEN without tlp_last: latch nullify=1, pulse oversize_err, go to TERM.
  - Bytes presented after the abort belong to the source to drop.
- DLLP_PAY:
  - dllp_ready = 1.
  - On dllp_valid: emit byte and increment count.
  - At count == DLLP_LEN-1 accepted: go to TERM with nullify=0.
- Underrun (valid low in any PAY state):
  - Emit EDB (dk=1).
  - Pulse underrun_err.
  - tlp_or_dllp -> 00.
  - Go to IDLE; the packet is aborted.
- TERM:
  - Emit EDB if the nullify latch is set, else END (dk=1).
  - tlp_or_dllp -> 00 on that output cycle.
  - Go to IDLE; clear counters and latch.
- Back-to-back: TERM -> IDLE -> start symbol on the next cycle. Gap = zero idle symbols between END and the next STP/SDP.
- Counter widths: clog2(MAX_TLP_LEN+1) bits for TLP; 3 bits minimum for DLLP. No wrap permitted.
- rst_n assertion mid-packet: immediate return to the reset values; no terminator is emitted.

Decomposition:
- Shared package pcie_framing_pkg holds:
  - The K-symbol constants (STP, SDP, END, EDB, PAD).
  - The tlp_or_dllp encodings (01/10/00).
  - The FSM state enum.
- The receive classifier uses the same package.
- No sub-module; a single flat FSM is natural.

Test Plan:
- DLLP of bytes 0x01..0x06, dllp_valid held:
  - Output sequence: SDP(K), 01..06(D), FD(K).
  - valid_out for 8 consecutive cycles.
  - tlp_or_dllp = 10 from SDP through the last data byte, 00 on END.
- TLP of 3 bytes AA,BB,CC, tlp_last on CC, nullify=0 -> FB(K), AA, BB, CC, FD(K).
- Same TLP with tlp_nullify=1 on the last byte -> terminator FE(K) instead of FD.
- tlp_valid and dllp_valid asserted in the same IDLE cycle -> SDP first, full DLLP, END, then STP on the very next cycle.
- tlp_valid dropped after the 2nd payload byte:
  - Next output is FE(K); underrun_err = 1 for one cycle; state returns to IDLE.
- MAX_TLP_LEN=4, 6-byte TLP with no last:
  - Output STP, 4 data bytes, FE(K); oversize_err pulses once.
- rst_n low during DLLP_PAY -> valid_out = 0 and tlp_or_dllp = 00 asynchronously; the next packet starts cleanly with SDP.

Source files
------------

// File: rtl/pcie_framing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_framing_pkg
// Description : Shared framing definitions for the PCIe 8b/10b byte lane.
//               Holds the K-symbol byte values, the tlp_or_dllp in-flight
//               encodings and the framer FSM state codes. The receive-side
//               byte classifier imports the same package so both ends agree
//               on symbol values.
// Contents    : K_STP/K_SDP/K_END/K_EDB/K_PAD  - control symbol bytes
//               TOD_NONE/TOD_TLP/TOD_DLLP      - tlp_or_dllp encodings
//               ST_IDLE/ST_TLP_PAY/ST_DLLP_PAY/ST_TERM - framer states
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_framing_pkg;

  // Control (K) symbol byte values
  localparam logic [7:0] K_STP = 8'hFB;  // start of TLP
  localparam logic [7:0] K_SDP = 8'h5C;  // start of DLLP
  localparam logic [7:0] K_END = 8'hFD;  // good end of packet
  localparam logic [7:0] K_EDB = 8'hFE;  // end bad / nullified packet
  localparam logic [7:0] K_PAD = 8'hF7;  // reserved, not emitted by the framer

  // tlp_or_dllp encodings
  localparam logic [1:0] TOD_NONE = 2'b00;
  localparam logic [1:0] TOD_TLP  = 2'b01;
  localparam logic [1:0] TOD_DLLP = 2'b10;

  // Framer FSM state codes
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TLP_PAY  = 2'd1;
  localparam logic [1:0] ST_DLLP_PAY = 2'd2;
  localparam logic [1:0] ST_TERM     = 2'd3;

endpackage : pcie_framing_pkg
`default_nettype wire

// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tx_framer
// Description : Transmit-side packet framer for the PCIe 8b/10b byte lane.
//               Wraps TLP byte streams in STP ... END/EDB and DLLP byte
//               streams in SDP ... END, emitting one byte per cycle with a
//               D/K flag ahead of the 8b/10b encoder.
// Ports       : clk, rst_n               - clock, async active-low reset
//               tlp_valid/data/last      - TLP byte stream in
//               tlp_nullify              - with tlp_last: terminate with EDB
//               tlp_ready                - TLP byte consumed this cycle
//               dllp_valid/data          - DLLP byte stream in
//               dllp_ready               - DLLP byte consumed this cycle
//               data_out/dk_out/valid_out- framed byte, K flag, qualifier
//               tlp_or_dllp              - packet type in flight
//               underrun_err             - pulse: source went idle mid-packet
//               oversize_err             - pulse: TLP hit MAX_TLP_LEN
// Revision    : 1.0 - initial release
// ============================================================================
module tx_framer
  import pcie_framing_pkg::*;
#(
  parameter int DLLP_LEN    = 6,
  parameter int MAX_TLP_LEN = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tlp_valid,
  input  logic [7:0] tlp_data,
  input  logic       tlp_last,
  input  logic       tlp_nullify,
  output logic       tlp_ready,
  input  logic       dllp_valid,
  input  logic [7:0] dllp_data,
  output logic       dllp_ready,
  output logic [7:0] data_out,
  output logic       dk_out,
  output logic       valid_out,
  output logic [1:0] tlp_or_dllp,
  output logic       underrun_err,
  output logic       oversize_err
);

  // TLP counter must hold MAX_TLP_LEN itself; DLLP counter is at least 3 bits.
  localparam int TCW = $clog2(MAX_TLP_LEN + 1);
  localparam int DCW = ($clog2(DLLP_LEN + 1) > 3) ? $clog2(DLLP_LEN + 1) : 3;

  localparam logic [TCW-1:0] TLP_MAX_C   = TCW'(MAX_TLP_LEN);
  localparam logic [DCW-1:0] DLLP_LAST_C = DCW'(DLLP_LEN - 1);

  logic [1:0]     state_q, state_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           null_q, null_d;
  logic [7:0]     data_q, data_d;
  logic           dk_q, dk_d;
  logic           valid_q, valid_d;
  logic [1:0]     tod_q, tod_d;
  logic           under_q, under_d;
  logic           over_q, over_d;

  logic [TCW-1:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + 1'b1;

  // Ready depends only on state so the source sees it before the edge.
  assign tlp_ready  = (state_q == ST_TLP_PAY);
  assign dllp_ready = (state_q == ST_DLLP_PAY);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    null_d  = null_q;
    data_d  = 8'h00;
    dk_d    = 1'b0;
    valid_d = 1'b0;
    tod_d   = tod_q;
    under_d = 1'b0;
    over_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        null_d = 1'b0;
        tod_d  = TOD_NONE;
        // DLLPs win a simultaneous request: they are short and carry
        // flow-control credits the link partner is waiting on.
        if (dllp_valid) begin
          data_d  = K_SDP;
          dk_d    = 1'b1;
          valid_d = 1'b1;
          tod_d   = TOD_DLLP;
          state_d = ST_DLLP_PAY;
        end else if (tlp_valid) begin
          data_d  = K_STP;
          dk_d    = 1'b1;
          valid_d = 1'b1;
          tod_d   = TOD_TLP;
          state_d = ST_TLP_PAY;
        end
      end

      ST_TLP_PAY: begin
        if (tlp_valid) begin
          data_d  = tlp_data;
          valid_d = 1'b1;
          tcnt_d  = tcnt_inc;
          if (tlp_last) begin
            null_d  = tlp_nullify;
            state_d = ST_TERM;
          end else if (tcnt_inc == TLP_MAX_C) begin
            // Length limit hit with no last flag: close the packet as bad.
            null_d  = 1'b1;
            over_d  = 1'b1;
            state_d = ST_TERM;
          end
        end else begin
          // Source ran dry mid-packet: abort immediately with EDB.
          data_d  = K_EDB;
          dk_d    = 1'b1;
          valid_d = 1'b1;
          under_d = 1'b1;
          tod_d   = TOD_NONE;
          tcnt_d  = '0;
          null_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_DLLP_PAY: begin
        if (dllp_valid) begin
          data_d  = dllp_data;
          valid_d = 1'b1;
          dcnt_d  = dcnt_q + 1'b1;
          if (dcnt_q == DLLP_LAST_C) begin
            null_d  = 1'b0;
            state_d = ST_TERM;
          end
        end else begin
          data_d  = K_EDB;
          dk_d    = 1'b1;
          valid_d = 1'b1;
          under_d = 1'b1;
          tod_d   = TOD_NONE;
          dcnt_d  = '0;
          null_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_TERM: begin
        data_d  = null_q ? K_EDB : K_END;
        dk_d    = 1'b1;
        valid_d = 1'b1;
        tod_d   = TOD_NONE;
        tcnt_d  = '0;
        dcnt_d  = '0;
        null_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      null_q  <= 1'b0;
      data_q  <= 8'h00;
      dk_q    <= 1'b0;
      valid_q <= 1'b0;
      tod_q   <= TOD_NONE;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      null_q  <= null_d;
      data_q  <= data_d;
      dk_q    <= dk_d;
      valid_q <= valid_d;
      tod_q   <= tod_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign data_out     = data_q;
  assign dk_out       = dk_q;
  assign valid_out    = valid_q;
  assign tlp_or_dllp  = tod_q;
  assign underrun_err = under_q;
  assign oversize_err = over_q;

endmodule : tx_framer
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_framer
// Description : Directed self-checking bench for tx_framer. The framer is
//               built with MAX_TLP_LEN=4 so the oversize abort is reachable
//               with a short packet; all other packets stay below that size.
//               Each observed symbol is packed as {valid,dk,tod[1:0],data}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_framer;

  logic       clk;
  logic       rst_n;
  logic       tlp_valid;
  logic [7:0] tlp_data;
  logic       tlp_last;
  logic       tlp_nullify;
  logic       tlp_ready;
  logic       dllp_valid;
  logic [7:0] dllp_data;
  logic       dllp_ready;
  logic [7:0] data_out;
  logic       dk_out;
  logic       valid_out;
  logic [1:0] tlp_or_dllp;
  logic       underrun_err;
  logic       oversize_err;

  int checks = 0;
  int errors = 0;

  tx_framer #(
    .DLLP_LEN    (6),
    .MAX_TLP_LEN (4)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tlp_valid    (tlp_valid),
    .tlp_data     (tlp_data),
    .tlp_last     (tlp_last),
    .tlp_nullify  (tlp_nullify),
    .tlp_ready    (tlp_ready),
    .dllp_valid   (dllp_valid),
    .dllp_data    (dllp_data),
    .dllp_ready   (dllp_ready),
    .data_out     (data_out),
    .dk_out       (dk_out),
    .valid_out    (valid_out),
    .tlp_or_dllp  (tlp_or_dllp),
    .underrun_err (underrun_err),
    .oversize_err (oversize_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sym(input logic v, input logic k,
                                      input logic [1:0] tod, input logic [7:0] d);
    return {20'd0, v, k, tod, d};
  endfunction

  function automatic logic [31:0] obs_sym();
    return {20'd0, valid_out, dk_out, tlp_or_dllp, data_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full 6-byte DLLP base..base+5 with dllp_valid held throughout.
  task automatic send_dllp(input logic [7:0] base, input string tag);
    dllp_valid = 1'b1;
    dllp_data  = base;
    step();
    check({tag, " SDP"}, obs_sym(), sym(1'b1, 1'b1, 2'b10, 8'h5C));
    for (int i = 0; i < 6; i++) begin
      check({tag, " dllp_ready"}, {31'd0, dllp_ready}, 32'd1);
      step();
      check({tag, " data"}, obs_sym(), sym(1'b1, 1'b0, 2'b10, base + 8'(i)));
      dllp_data = base + 8'(i + 1);
      if (i == 5) dllp_valid = 1'b0;
    end
    step();
    check({tag, " END"}, obs_sym(), sym(1'b1, 1'b1, 2'b00, 8'hFD));
  endtask

  // 3-byte TLP AA,BB,CC with the given nullify on the last byte.
  task automatic send_tlp3(input logic nul, input logic [7:0] term, input string tag);
    tlp_valid = 1'b1;
    tlp_data  = 8'hAA;
    step();
    check({tag, " STP"}, obs_sym(), sym(1'b1, 1'b1, 2'b01, 8'hFB));
    step();
    check({tag, " AA"}, obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'hAA));
    tlp_data = 8'hBB;
    step();
    check({tag, " BB"}, obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'hBB));
    tlp_data    = 8'hCC;
    tlp_last    = 1'b1;
    tlp_nullify = nul;
    step();
    check({tag, " CC"}, obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'hCC));
    tlp_valid   = 1'b0;
    tlp_last    = 1'b0;
    tlp_nullify = 1'b0;
    step();
    check({tag, " term"}, obs_sym(), sym(1'b1, 1'b1, 2'b00, term));
    step();
    check({tag, " idle"}, obs_sym(), sym(1'b0, 1'b0, 2'b00, 8'h00));
  endtask

  initial begin
    rst_n       = 1'b0;
    tlp_valid   = 1'b0;
    tlp_data    = 8'h00;
    tlp_last    = 1'b0;
    tlp_nullify = 1'b0;
    dllp_valid  = 1'b0;
    dllp_data   = 8'h00;

    // Reset state
    step();
    step();
    check("reset sym", obs_sym(), 32'd0);
    check("reset ready", {30'd0, tlp_ready, dllp_ready}, 32'd0);
    check("reset errs", {30'd0, underrun_err, oversize_err}, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle after reset", obs_sym(), 32'd0);

    // DLLP 01..06
    send_dllp(8'h01, "dllp1");
    step();
    check("dllp1 idle", obs_sym(), 32'd0);

    // TLP good and nullified
    send_tlp3(1'b0, 8'hFD, "tlp_end");
    send_tlp3(1'b1, 8'hFE, "tlp_edb");

    // Simultaneous request: DLLP first, then STP with zero gap
    tlp_valid = 1'b1;
    tlp_data  = 8'hAA;
    send_dllp(8'h01, "prio");
    step();
    check("prio STP", obs_sym(), sym(1'b1, 1'b1, 2'b01, 8'hFB));
    tlp_last = 1'b1;
    step();
    check("prio AA", obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'hAA));
    tlp_valid = 1'b0;
    tlp_last  = 1'b0;
    step();
    check("prio END", obs_sym(), sym(1'b1, 1'b1, 2'b00, 8'hFD));
    step();
    check("prio idle", obs_sym(), 32'd0);

    // Underrun after 2 payload bytes
    tlp_valid = 1'b1;
    tlp_data  = 8'h11;
    step();
    check("ur STP", obs_sym(), sym(1'b1, 1'b1, 2'b01, 8'hFB));
    step();
    check("ur 11", obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'h11));
    tlp_data = 8'h22;
    step();
    check("ur 22", obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'h22));
    check("ur no pulse yet", {31'd0, underrun_err}, 32'd0);
    tlp_valid = 1'b0;
    step();
    check("ur EDB", obs_sym(), sym(1'b1, 1'b1, 2'b00, 8'hFE));
    check("ur pulse", {31'd0, underrun_err}, 32'd1);
    step();
    check("ur pulse gone", {31'd0, underrun_err}, 32'd0);
    check("ur idle", obs_sym(), 32'd0);
    check("ur ready", {30'd0, tlp_ready, dllp_ready}, 32'd0);

    // Oversize: 6 bytes offered, no last, limit 4
    tlp_valid = 1'b1;
    tlp_data  = 8'h31;
    step();
    check("ov STP", obs_sym(), sym(1'b1, 1'b1, 2'b01, 8'hFB));
    for (int i = 0; i < 4; i++) begin
      step();
      check("ov data", obs_sym(), sym(1'b1, 1'b0, 2'b01, 8'h31 + 8'(i)));
      check("ov pulse", {31'd0, oversize_err}, (i == 3) ? 32'd1 : 32'd0);
      tlp_data = 8'h32 + 8'(i);
    end
    check("ov ready dropped", {31'd0, tlp_ready}, 32'd0);
    step();
    check("ov EDB", obs_sym(), sym(1'b1, 1'b1, 2'b00, 8'hFE));
    check("ov pulse gone", {31'd0, oversize_err}, 32'd0);
    check("ov no underrun", {31'd0, underrun_err}, 32'd0);
    tlp_valid = 1'b0;
    step();
    check("ov idle", obs_sym(), 32'd0);

    // Async reset in the middle of a DLLP
    dllp_valid = 1'b1;
    dllp_data  = 8'h01;
    step();
    check("rst SDP", obs_sym(), sym(1'b1, 1'b1, 2'b10, 8'h5C));
    step();
    dllp_data = 8'h02;
    step();
    check("rst pre 02", obs_sym(), sym(1'b1, 1'b0, 2'b10, 8'h02));
    #2 rst_n = 1'b0;
    #1;
    check("rst async sym", obs_sym(), 32'd0);
    dllp_valid = 1'b0;
    step();
    step();
    check("rst held", obs_sym(), 32'd0);
    rst_n = 1'b1;
    send_dllp(8'h41, "post_rst");
    step();
    check("post_rst idle", obs_sym(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tx_framer
`default_nettype wire
